// File: rtl/calc_key_sequencer_pkg.sv
// Shared definitions for the calculator key sequencer.
// Holds the clear-all key code and the sequencer FSM state type.
package calc_key_sequencer_pkg;

  // Native key code width of the keypad decoder.
  localparam int unsigned KeyW = 5;

  // Clear-all key code. It bypasses the full check and flushes stale keys.
  localparam logic [KeyW-1:0] KeyCa = 5'b00011;

  // Sequencer states: wait for work, strobe one key, enforce the idle gap.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StHold  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/calc_key_fifo.sv
// Key FIFO for the calculator key sequencer.
// DEPTH entries of KEY_W bits with wrapping pointers. flush_load discards everything
// and writes wdata as the only entry; it takes priority over push and pop.
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-low reset
//   push, wdata        enqueue wdata at tail (ignored when full)
//   pop                dequeue head (ignored when empty)
//   flush_load         discard all entries, wdata becomes the single entry
//   rdata              current head entry
//   full, empty, count occupancy status
module calc_key_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned KEY_W = 5
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush_load,
  input  logic [KEY_W-1:0]             wdata,
  output logic [KEY_W-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);

  logic [KEY_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;
  logic             mem_we;
  logic [PtrW-1:0]  mem_widx;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // A flush restarts the ring at slot 0 so the loaded entry is the new head.
  assign mem_we   = flush_load || do_push;
  assign mem_widx = flush_load ? '0 : wr_ptr_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_load) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= PtrW'(1);
      count_q  <= CntW'(1);
    end else begin
      // DEPTH is a power of two, so pointer overflow wraps modulo DEPTH.
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        count_q <= count_q + CntW'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // Storage carries no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[mem_widx] <= wdata;
  end

endmodule

// File: rtl/calc_key_sequencer.sv
// Calculator key sequencer.
// Buffers decoded key events and replays them to the calculator core as one-cycle
// newkey/keycode strobes, forcing GAP idle cycles after each strobe and waiting while
// the core is busy. Clear-all flushes pending keys and becomes the only entry.
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   key_valid, key_code   decoded key event from the keypad decoder
//   key_ready             FIFO not full (clear-all is accepted regardless)
//   core_busy             core cannot take a key; only looked at while idle
//   newkey, keycode       one-cycle strobe and key for the core
//   overflow              sticky flag: a non-clear-all key was dropped
//   fifo_count            entries currently buffered
//   idle                  no strobe in progress and nothing buffered
module calc_key_sequencer
  import calc_key_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned GAP   = 2,
  parameter int unsigned KEY_W = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       key_valid,
  input  logic [KEY_W-1:0]           key_code,
  output logic                       key_ready,
  input  logic                       core_busy,
  output logic                       newkey,
  output logic [KEY_W-1:0]           keycode,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       idle
);

  localparam int unsigned CntW = $clog2(DEPTH+1);
  // The hold counter runs GAP-1 down to 0, so it only needs to hold GAP-1.
  localparam int unsigned GapW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GapW-1:0] GapLoad = GapW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [KEY_W-1:0] CaCode = KEY_W'(KeyCa);

  seq_state_e       state_q, state_d;
  logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
  logic             newkey_q, newkey_d;
  logic [KEY_W-1:0] keycode_q, keycode_d;
  logic             overflow_q, overflow_d;
  logic             pop_ok_q, pop_ok_d;

  logic             key_is_ca;
  logic             fifo_push, fifo_pop, fifo_flush;
  logic             fifo_full, fifo_empty;
  logic [KEY_W-1:0] fifo_head;
  logic [CntW-1:0]  fifo_cnt;
  logic             drop;

  assign key_is_ca  = key_valid && (key_code == CaCode);
  assign fifo_push  = key_valid && !key_is_ca;
  assign fifo_flush = key_is_ca;
  assign drop       = fifo_push && fifo_full;
  // Pop the strobed key at the end of the issue cycle, unless a flush landed on the
  // same edge that started the strobe: the head is then the clear-all, not our key.
  assign fifo_pop   = (state_q == StIssue) && pop_ok_q;

  calc_key_fifo #(
    .DEPTH (DEPTH),
    .KEY_W (KEY_W)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (fifo_push),
    .pop        (fifo_pop),
    .flush_load (fifo_flush),
    .wdata      (key_code),
    .rdata      (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_cnt)
  );

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    newkey_d  = 1'b0;
    keycode_d = keycode_q;
    pop_ok_d  = pop_ok_q;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty && !core_busy) begin
          state_d   = StIssue;
          newkey_d  = 1'b1;
          keycode_d = fifo_head;
          pop_ok_d  = !fifo_flush;
        end
      end
      StIssue: begin
        if (GAP > 0) begin
          state_d   = StHold;
          gap_cnt_d = GapLoad;
        end else begin
          state_d = StIdle;
        end
      end
      StHold: begin
        if (gap_cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // A drop on the same cycle as the clearing strobe keeps the flag set.
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (newkey_q && (keycode_q == CaCode)) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      gap_cnt_q  <= '0;
      newkey_q   <= 1'b0;
      keycode_q  <= '0;
      overflow_q <= 1'b0;
      pop_ok_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      newkey_q   <= newkey_d;
      keycode_q  <= keycode_d;
      overflow_q <= overflow_d;
      pop_ok_q   <= pop_ok_d;
    end
  end

  assign newkey     = newkey_q;
  assign keycode    = keycode_q;
  assign overflow   = overflow_q;
  assign fifo_count = fifo_cnt;
  assign key_ready  = !fifo_full;
  assign idle       = (state_q == StIdle) && fifo_empty;

endmodule
